// File: rtl/srb_chain_cfg_pkg.sv
// -----------------------------------------------------------------------------
// srb_pkg
//  Shared definitions for the configurable SRB chain.
//  SRB_DEF_STAGES / SRB_DEF_W : default chain length and data width.
//  srb_word_t                 : valid + data pair held by one stage at the
//                               default width. Stage ports use the same packed
//                               {valid, data} layout, with DATA_W bits of data.
// -----------------------------------------------------------------------------
package srb_pkg;

  localparam int SRB_DEF_STAGES = 12;
  localparam int SRB_DEF_W      = 1;

  typedef struct packed {
    logic                 valid;
    logic [SRB_DEF_W-1:0] data;
  } srb_word_t;

endpackage

// File: rtl/srb_chain_cfg_if.sv
// -----------------------------------------------------------------------------
// srb_chain_cfg_if
//  Bundle of control, data, configuration and observation signals of the SRB
//  chain.
//  master : the block driving the chain (start/flush/data/config/tap_sel).
//  slave  : the chain itself (out_*, tap_*, busy, cfg_pending, depth_o).
// -----------------------------------------------------------------------------
interface srb_chain_cfg_if
  import srb_pkg::*;
#(
  parameter int N_STAGES = SRB_DEF_STAGES,
  parameter int DATA_W   = SRB_DEF_W,
  parameter int SEL_W    = $clog2(N_STAGES),
  parameter int LAT_W    = $clog2(N_STAGES + 1)
) ();

  logic                start;
  logic                flush;
  logic [DATA_W-1:0]   in_data;
  logic                in_valid;
  logic                cfg_load;
  logic [N_STAGES-1:0] cfg_toggle;
  logic [SEL_W-1:0]    tap_sel;

  logic [DATA_W-1:0]   out_data;
  logic                out_valid;
  logic [DATA_W-1:0]   tap_data;
  logic                tap_valid;
  logic                busy;
  logic                cfg_pending;
  logic [LAT_W-1:0]    depth_o;

  modport master (
    output start, flush, in_data, in_valid, cfg_load, cfg_toggle, tap_sel,
    input  out_data, out_valid, tap_data, tap_valid, busy, cfg_pending, depth_o
  );

  modport slave (
    input  start, flush, in_data, in_valid, cfg_load, cfg_toggle, tap_sel,
    output out_data, out_valid, tap_data, tap_valid, busy, cfg_pending, depth_o
  );

endinterface

// File: rtl/srb_chain_cfg_stage.sv
// -----------------------------------------------------------------------------
// srb_stage
//  One DATA_W-bit SRB cell holding a packed {valid, data} word.
//  clk, rst : clock, synchronous active-high reset
//  start    : 1 = load a new word, 0 = hold
//  flush    : clear the valid bit (data follows the start rule)
//  toggle   : 1 = load the shortcut input, 0 = load the previous stage
//  in1      : previous stage word
//  in2      : chain input word (shortcut)
//  out      : registered word
// -----------------------------------------------------------------------------
module srb_stage
  import srb_pkg::*;
#(
  parameter int DATA_W = SRB_DEF_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic            toggle,
  input  logic [DATA_W:0] in1,
  input  logic [DATA_W:0] in2,
  output logic [DATA_W:0] out
);

  logic [DATA_W:0] word_q, word_d;

  // NOTE: start with a hold default so every path assigns word_d; a missing
  // default in always_comb would infer a latch.
  always_comb begin
    word_d = word_q;
    if (start) word_d = toggle ? in2 : in1;
    if (flush) word_d[DATA_W] = 1'b0;
  end

  // NOTE: state uses non-blocking assignments so every stage samples its
  // neighbour's pre-edge value; blocking here would collapse the shift chain.
  // NOTE: data registers are reset too, so a reset also wipes stale data seen
  // on the tap and output ports.
  always_ff @(posedge clk) begin
    if (rst) word_q <= '0;
    else     word_q <= word_d;
  end

  assign out = word_q;

endmodule

// File: rtl/srb_chain_cfg.sv
// -----------------------------------------------------------------------------
// srb_chain_cfg
//  Chain of N_STAGES SRB cells with per-stage shortcut to the chain input,
//  giving a runtime-selectable latency of 1..N_STAGES.
//  clk, rst : clock, synchronous active-high reset
//  bus      : srb_chain_cfg_if.slave
//    start/flush          advance / invalidate control
//    in_data/in_valid     chain input word
//    cfg_load/cfg_toggle  shortcut configuration request (shadowed)
//    tap_sel              stage observed on tap_data/tap_valid
//    out_data/out_valid   last stage word
//    busy                 any stage valid
//    cfg_pending          a configuration waits for the chain to drain
//    depth_o              active latency
// -----------------------------------------------------------------------------
module srb_chain_cfg
  import srb_pkg::*;
#(
  parameter int N_STAGES = SRB_DEF_STAGES,
  parameter int DATA_W   = SRB_DEF_W,
  parameter int SEL_W    = $clog2(N_STAGES),
  parameter int LAT_W    = $clog2(N_STAGES + 1)
) (
  input  logic           clk,
  input  logic           rst,
  srb_chain_cfg_if.slave bus
);

  logic [DATA_W:0]     in_word;
  logic [DATA_W:0]     stage_q [N_STAGES];
  logic [N_STAGES-1:0] valid_w;
  logic                busy;

  logic [N_STAGES-1:0] toggle_q, toggle_d;
  logic [N_STAGES-1:0] pend_q, pend_d;
  logic                pending_q, pending_d;

  assign in_word = {bus.in_valid, bus.in_data};

  for (genvar i = 0; i < N_STAGES; i++) begin : g_stage
    logic [DATA_W:0] prev_w;
    logic            toggle_w;

    if (i == 0) begin : g_head
      // Stage 0 always takes the chain input; toggle_q[0] has no effect.
      assign prev_w   = in_word;
      assign toggle_w = 1'b0;
    end else begin : g_body
      assign prev_w   = stage_q[i-1];
      assign toggle_w = toggle_q[i];
    end

    srb_stage #(.DATA_W(DATA_W)) u_stage (
      .clk    (clk),
      .rst    (rst),
      .start  (bus.start),
      .flush  (bus.flush),
      .toggle (toggle_w),
      .in1    (prev_w),
      .in2    (in_word),
      .out    (stage_q[i])
    );

    assign valid_w[i] = stage_q[i][DATA_W];
  end

  assign busy = |valid_w;

  // A new configuration only takes effect on an empty chain. While data is in
  // flight it is parked in pend_q (last request wins) and applied on the first
  // edge that sees the chain idle. A direct load on an idle chain supersedes a
  // parked value.
  always_comb begin
    toggle_d  = toggle_q;
    pend_d    = pend_q;
    pending_d = pending_q;
    if (bus.cfg_load) begin
      if (!busy) begin
        toggle_d  = bus.cfg_toggle;
        pending_d = 1'b0;
      end else begin
        pend_d    = bus.cfg_toggle;
        pending_d = 1'b1;
      end
    end else if (pending_q && !busy) begin
      toggle_d  = pend_q;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      toggle_q  <= '0;
      pend_q    <= '0;
      pending_q <= 1'b0;
    end else begin
      toggle_q  <= toggle_d;
      pend_q    <= pend_d;
      pending_q <= pending_d;
    end
  end

  // Tap mux driven by tap_sel only; out-of-range selects read as zero.
  always_comb begin
    bus.tap_data  = '0;
    bus.tap_valid = 1'b0;
    for (int i = 0; i < N_STAGES; i++) begin
      if (bus.tap_sel == SEL_W'(i)) begin
        bus.tap_data  = stage_q[i][DATA_W-1:0];
        bus.tap_valid = stage_q[i][DATA_W];
      end
    end
  end

  // The highest shortcut stage k determines latency; bit 0 maps to k = 0,
  // which is the same as no shortcut.
  logic [LAT_W-1:0] high_k;

  always_comb begin
    high_k = '0;
    for (int i = 0; i < N_STAGES; i++) begin
      if (toggle_q[i]) high_k = LAT_W'(i);
    end
  end

  assign bus.depth_o     = LAT_W'(N_STAGES) - high_k;
  assign bus.out_data    = stage_q[N_STAGES-1][DATA_W-1:0];
  assign bus.out_valid   = stage_q[N_STAGES-1][DATA_W];
  assign bus.busy        = busy;
  assign bus.cfg_pending = pending_q;

endmodule

// File: tb/tb_srb_chain_cfg.sv
// -----------------------------------------------------------------------------
// tb_srb_chain_cfg
//  Self-checking bench for srb_chain_cfg (N_STAGES=12, DATA_W=8).
//  A word-level reference model tracks every stage word by position; it is
//  compared against all DUT outputs after every clock edge, alongside directed
//  sequences, a table of configuration vectors and a randomized phase.
// -----------------------------------------------------------------------------
module tb_srb_chain_cfg;
  import srb_pkg::*;

  localparam int N     = 12;
  localparam int W     = 8;
  localparam int SEL_W = $clog2(N);
  localparam int LAT_W = $clog2(N + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  srb_chain_cfg_if #(.N_STAGES(N), .DATA_W(W)) bus ();

  srb_chain_cfg #(.N_STAGES(N), .DATA_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a list of words, each tagged with the stage it occupies.
  // On an advancing edge every word moves one stage on, words leaving the end
  // or landing on a shortcut stage disappear, and the input word appears at
  // stage 0 and at every shortcut stage.
  // ---------------------------------------------------------------------------
  typedef struct {
    int           pos;
    logic         v;
    logic [W-1:0] d;
  } mword_t;

  mword_t         mq[$];
  logic [N-1:0]   m_toggle, m_pend;
  logic           m_pending;

  function automatic bit m_busy();
    foreach (mq[i]) if (mq[i].v) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_depth();
    for (int k = N - 1; k >= 1; k--) if (m_toggle[k]) return N - k;
    return N;
  endfunction

  task automatic m_lookup(input int p, output logic v, output logic [W-1:0] d);
    v = 1'b0;
    d = '0;
    foreach (mq[i]) if (mq[i].pos == p) begin
      v = mq[i].v;
      d = mq[i].d;
    end
  endtask

  task automatic model_edge(input logic r, s, f, iv, input logic [W-1:0] id,
                            input logic cl, input logic [N-1:0] ct);
    mword_t       nq[$];
    logic [N-1:0] nt, np;
    logic         npend;
    bit           b;
    if (r) begin
      mq.delete();
      for (int i = 0; i < N; i++) mq.push_back('{pos: i, v: 1'b0, d: '0});
      m_toggle  = '0;
      m_pend    = '0;
      m_pending = 1'b0;
      return;
    end
    b     = m_busy();
    nt    = m_toggle;
    np    = m_pend;
    npend = m_pending;
    if (cl && !b) begin
      nt    = ct;
      npend = 1'b0;
    end else if (cl) begin
      np    = ct;
      npend = 1'b1;
    end else if (m_pending && !b) begin
      nt    = m_pend;
      npend = 1'b0;
    end
    if (s) begin
      foreach (mq[i]) begin
        int p = mq[i].pos + 1;
        if (p < N && !m_toggle[p]) nq.push_back('{pos: p, v: mq[i].v, d: mq[i].d});
      end
      nq.push_back('{pos: 0, v: iv, d: id});
      for (int k = 1; k < N; k++)
        if (m_toggle[k]) nq.push_back('{pos: k, v: iv, d: id});
      mq = nq;
    end
    if (f) foreach (mq[i]) mq[i].v = 1'b0;
    m_toggle  = nt;
    m_pend    = np;
    m_pending = npend;
  endtask

  task automatic compare_model(input logic [SEL_W-1:0] ts);
    logic         v;
    logic [W-1:0] d;
    m_lookup(N - 1, v, d);
    check("m_out_valid", bus.out_valid, v);
    check("m_out_data", bus.out_data, d);
    if (int'(ts) < N) m_lookup(int'(ts), v, d);
    else begin
      v = 1'b0;
      d = '0;
    end
    check("m_tap_valid", bus.tap_valid, v);
    check("m_tap_data", bus.tap_data, d);
    check("m_busy", bus.busy, m_busy());
    check("m_cfg_pending", bus.cfg_pending, m_pending);
    check("m_depth", bus.depth_o, m_depth());
  endtask

  // One clock: drive inputs, clock, update model, compare after the edge.
  task automatic step(input logic r, s, f, iv, input logic [W-1:0] id,
                      input logic cl, input logic [N-1:0] ct, input logic [SEL_W-1:0] ts);
    rst            = r;
    bus.start      = s;
    bus.flush      = f;
    bus.in_valid   = iv;
    bus.in_data    = id;
    bus.cfg_load   = cl;
    bus.cfg_toggle = ct;
    bus.tap_sel    = ts;
    @(posedge clk);
    model_edge(r, s, f, iv, id, cl, ct);
    #1;
    compare_model(ts);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0);
  endtask

  typedef struct {
    logic         s, f, iv;
    logic [W-1:0] id;
    logic         cl;
    logic [N-1:0] ct;
    logic         eov;
    logic [W-1:0] eod;
    logic         ebusy, epend;
    int           edepth;
  } vec_t;

  vec_t tbl[14];

  initial begin
    // Configuration vectors, applied from reset with toggle_q = 0.
    tbl[0]  = '{1, 0, 1, 8'h03, 0, 12'h000, 0, 8'h00, 1, 0, 12};
    tbl[1]  = '{1, 0, 0, 8'h00, 1, 12'h010, 0, 8'h00, 1, 1, 12}; // busy: park
    tbl[2]  = '{1, 0, 0, 8'h00, 1, 12'h040, 0, 8'h00, 1, 1, 12}; // last wins
    tbl[3]  = '{1, 1, 1, 8'h07, 0, 12'h000, 0, 8'h00, 0, 1, 12}; // flush beats in_valid
    tbl[4]  = '{1, 0, 0, 8'h00, 0, 12'h000, 0, 8'h00, 0, 0, 6};  // parked 0x040 applies
    tbl[5]  = '{1, 0, 0, 8'h00, 1, 12'h800, 0, 8'h00, 0, 0, 1};  // idle: direct
    tbl[6]  = '{1, 0, 1, 8'h09, 0, 12'h000, 1, 8'h09, 1, 0, 1};  // latency 1
    tbl[7]  = '{1, 1, 0, 8'h00, 1, 12'h000, 0, 8'h00, 0, 1, 1};
    tbl[8]  = '{1, 0, 0, 8'h00, 0, 12'h000, 0, 8'h00, 0, 0, 12};
    tbl[9]  = '{1, 0, 1, 8'h05, 0, 12'h000, 0, 8'h00, 1, 0, 12};
    tbl[10] = '{1, 0, 0, 8'h00, 1, 12'h100, 0, 8'h00, 1, 1, 12};
    tbl[11] = '{0, 1, 0, 8'h00, 0, 12'h000, 0, 8'h00, 0, 1, 12}; // flush while frozen
    tbl[12] = '{1, 0, 0, 8'h00, 1, 12'h002, 0, 8'h00, 0, 0, 11}; // direct, 0x100 dropped
    tbl[13] = '{1, 0, 0, 8'h00, 0, 12'h000, 0, 8'h00, 0, 0, 11};

    // Reset state.
    do_reset();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_depth", bus.depth_o, N);

    // T1 + T3: one word at full depth; a config requested while busy waits
    // until the word has left the chain (edge 13), then applies at edge 14.
    do_reset();
    for (int e = 1; e <= 16; e++) begin
      step(0, 1, 0, e == 1, 8'h01, e == 2, 12'h010, 4);
      check("t1_out_valid", bus.out_valid, e == 12);
      if (e == 12) check("t1_out_data", bus.out_data, 8'h01);
      check("t1_pending", bus.cfg_pending, e >= 2 && e <= 13);
      check("t1_depth", bus.depth_o, (e >= 14) ? 8 : 12);
    end

    // T2: shortcut at stage 9 -> depth 3. A enters stage 0 and stage 9 at
    // edge 1; the stage-9 copy exits at edge 3, the stage-0 copy is
    // overwritten at stage 9 and never shows at edge 12. B exits at edge 5.
    do_reset();
    step(0, 1, 0, 0, 8'h00, 1, 12'h200, 0);
    check("t2_depth", bus.depth_o, 3);
    for (int e = 1; e <= 14; e++) begin
      step(0, 1, 0, e == 1 || e == 3, (e == 1) ? 8'h11 : 8'h01, 0, '0, 0);
      check("t2_out_valid", bus.out_valid, e == 3 || e == 5);
      if (e == 3) check("t2_out_data_a", bus.out_data, 8'h11);
      if (e == 5) check("t2_out_data_b", bus.out_data, 8'h01);
    end

    // Configuration table.
    do_reset();
    foreach (tbl[i]) begin
      step(0, tbl[i].s, tbl[i].f, tbl[i].iv, tbl[i].id, tbl[i].cl, tbl[i].ct, 4);
      check("tbl_out_valid", bus.out_valid, tbl[i].eov);
      if (tbl[i].eov) check("tbl_out_data", bus.out_data, tbl[i].eod);
      check("tbl_busy", bus.busy, tbl[i].ebusy);
      check("tbl_pending", bus.cfg_pending, tbl[i].epend);
      check("tbl_depth", bus.depth_o, tbl[i].edepth);
    end

    // T4: freeze for 5 edges (5..9) while the word sits in stage 3.
    do_reset();
    for (int e = 1; e <= 20; e++) begin
      step(0, !(e >= 5 && e <= 9), 0, e == 1, 8'h5C, 0, '0, 3);
      check("t4_out_valid", bus.out_valid, e == 17);
      if (e >= 4 && e <= 9) begin
        check("t4_tap_valid", bus.tap_valid, 1);
        check("t4_tap_data", bus.tap_data, 8'h5C);
      end
    end

    // T5: three words in flight, config parked, flush empties the chain and
    // the parked config lands one edge later; nothing ever reaches the output.
    do_reset();
    for (int e = 1; e <= 18; e++) begin
      step(0, 1, e == 5, e <= 3, 8'(e), e == 4, 12'h008, 0);
      check("t5_out_valid", bus.out_valid, 0);
      if (e == 4) check("t5_pending", bus.cfg_pending, 1);
      if (e == 5) check("t5_busy", bus.busy, 0);
      if (e == 6) begin
        check("t5_pending_clr", bus.cfg_pending, 0);
        check("t5_depth", bus.depth_o, 9);
      end
    end

    // T6: tap follows stage 4, out-of-range tap reads zero, reset mid-flight.
    do_reset();
    for (int e = 1; e <= 8; e++) begin
      step(0, 1, 0, 1, 8'hA5, 0, '0, 4);
      if (e >= 5) begin
        check("t6_tap_valid", bus.tap_valid, 1);
        check("t6_tap_data", bus.tap_data, 8'hA5);
      end
    end
    step(0, 1, 0, 1, 8'hA5, 0, '0, 15);
    check("t6_tap15_valid", bus.tap_valid, 0);
    check("t6_tap15_data", bus.tap_data, 0);
    step(1, 1, 0, 1, 8'hA5, 1, 12'hFFF, 4);
    check("t6_rst_out_data", bus.out_data, 0);
    check("t6_rst_out_valid", bus.out_valid, 0);
    check("t6_rst_busy", bus.busy, 0);
    check("t6_rst_pending", bus.cfg_pending, 0);
    check("t6_rst_depth", bus.depth_o, N);
    check("t6_rst_tap", bus.tap_data, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 31) == 0,
           $urandom_range(0, 1) == 1,
           W'($urandom()),
           $urandom_range(0, 15) == 0,
           N'($urandom() & $urandom()),
           SEL_W'($urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
